// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the load/writeback stage:
// load funct3 encodings, stage states and datapath defaults.
package rv32_pkg;

    localparam int DEF_XLEN    = 32;
    localparam int DEF_RADDR_W = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        IDLE,
        REQ
    } lwb_state_e;

endpackage

// File: rtl/load_writeback_if.sv
// Execute-to-writeback handshake plus the single-beat
// data-bus read channel used by loads.
interface load_writeback_if #(
    parameter int XLEN    = rv32_pkg::DEF_XLEN,
    parameter int RADDR_W = rv32_pkg::DEF_RADDR_W
) ();

    logic               in_valid;
    logic               in_ready;
    logic               in_is_load;
    logic               in_wen;
    logic [2:0]         in_funct3;
    logic [RADDR_W-1:0] in_rd;
    logic [XLEN-1:0]    in_result;

    logic               mem_req;
    logic [XLEN-1:0]    mem_addr;
    logic               mem_ack;
    logic [XLEN-1:0]    mem_rdata;

    modport slave (
        input  in_valid, in_is_load, in_wen,
        input  in_funct3, in_rd, in_result,
        input  mem_ack, mem_rdata,
        output in_ready, mem_req, mem_addr
    );

    modport master (
        output in_valid, in_is_load, in_wen,
        output in_funct3, in_rd, in_result,
        output mem_ack, mem_rdata,
        input  in_ready, mem_req, mem_addr
    );

endinterface

// File: rtl/load_writeback_align.sv
// Load data alignment/extension and legality check for
// a word read at byte offset off_i.
module load_align
    import rv32_pkg::*;
#(
    parameter int XLEN = DEF_XLEN
) (
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      off_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [XLEN-1:0] data_o,
    output logic            illegal_o
);

    logic [XLEN-1:0] sh;

    // legal halves have off[0]=0, so a byte shift covers them too
    assign sh = rdata_i >> {off_i, 3'b000};

    always_comb begin
        data_o    = '0;
        illegal_o = 1'b0;
        unique case (1'b1)
            funct3_i == F3_LB:
                data_o = {{(XLEN-8){sh[7]}}, sh[7:0]};
            funct3_i == F3_LBU:
                data_o = {{(XLEN-8){1'b0}}, sh[7:0]};
            funct3_i == F3_LH: begin
                data_o    = {{(XLEN-16){sh[15]}}, sh[15:0]};
                illegal_o = off_i[0];
            end
            funct3_i == F3_LHU: begin
                data_o    = {{(XLEN-16){1'b0}}, sh[15:0]};
                illegal_o = off_i[0];
            end
            funct3_i == F3_LW: begin
                data_o    = sh;
                illegal_o = |off_i;
            end
            default:
                illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/load_writeback.sv
// Memory/writeback stage: ALU results go straight to the
// register file, loads do one bus read then align/extend.
module load_writeback
    import rv32_pkg::*;
#(
    parameter int XLEN    = DEF_XLEN,
    parameter int RADDR_W = DEF_RADDR_W
) (
    input  logic               CLK,
    input  logic               RST_N,
    load_writeback_if.slave    bus,
    output logic               WRITE,
    output logic [RADDR_W-1:0] inaddr_w,
    output logic [XLEN-1:0]    indata_w,
    output logic               fault,
    output logic               busy
);

    lwb_state_e         state_q;
    logic               write_q;
    logic [RADDR_W-1:0] waddr_q;
    logic [XLEN-1:0]    wdata_q;
    logic               req_q;
    logic [XLEN-1:0]    maddr_q;
    logic               fault_q;
    logic               busy_q;
    logic [RADDR_W-1:0] rd_q;
    logic               wen_q;
    logic [2:0]         f3_q;
    logic [1:0]         off_q;

    logic               in_req;
    logic [2:0]         al_f3;
    logic [1:0]         al_off;
    logic [XLEN-1:0]    al_data;
    logic               al_illegal;

    // one aligner: checks the incoming load in IDLE,
    // extends the returned data while in REQ
    assign in_req = (state_q == REQ);
    assign al_f3  = in_req ? f3_q  : bus.in_funct3;
    assign al_off = in_req ? off_q : bus.in_result[1:0];

    load_align #(
        .XLEN(XLEN)
    ) u_align (
        .funct3_i (al_f3),
        .off_i    (al_off),
        .rdata_i  (bus.mem_rdata),
        .data_o   (al_data),
        .illegal_o(al_illegal)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            req_q   <= 1'b0;
            maddr_q <= '0;
            fault_q <= 1'b0;
            busy_q  <= 1'b0;
            rd_q    <= '0;
            wen_q   <= 1'b0;
            f3_q    <= '0;
            off_q   <= '0;
        end else begin
            write_q <= 1'b0;
            fault_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (!bus.in_is_load) begin
                            write_q <= bus.in_wen
                                && (bus.in_rd != '0);
                            waddr_q <= bus.in_rd;
                            wdata_q <= bus.in_result;
                        end else if (al_illegal) begin
                            fault_q <= 1'b1;
                        end else begin
                            rd_q    <= bus.in_rd;
                            wen_q   <= bus.in_wen;
                            f3_q    <= bus.in_funct3;
                            off_q   <= bus.in_result[1:0];
                            req_q   <= 1'b1;
                            maddr_q <= {bus.in_result[XLEN-1:2],
                                        2'b00};
                            busy_q  <= 1'b1;
                            state_q <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (bus.mem_ack) begin
                        req_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                        write_q <= wen_q && (rd_q != '0);
                        waddr_q <= rd_q;
                        wdata_q <= al_data;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready = (state_q == IDLE);
    assign bus.mem_req  = req_q;
    assign bus.mem_addr = maddr_q;
    assign WRITE        = write_q;
    assign inaddr_w     = waddr_q;
    assign indata_w     = wdata_q;
    assign fault        = fault_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_load_writeback.sv
// Randomized bench for load_writeback against a timeline
// model of expected writes, faults and bus requests.
module tb_load_writeback;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
    } wr_t;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        WRITE;
    logic [4:0]  inaddr_w;
    logic [31:0] indata_w;
    logic        fault;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    wr_t         exp_w[int];
    bit          exp_f[int];
    logic [31:0] exp_r[int];

    bit w_e;
    bit r_e;

    load_writeback_if #(.XLEN(32), .RADDR_W(5)) bus ();

    load_writeback #(.XLEN(32), .RADDR_W(5)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .bus     (bus),
        .WRITE   (WRITE),
        .inaddr_w(inaddr_w),
        .indata_w(indata_w),
        .fault   (fault),
        .busy    (busy)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h (cyc %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic bit legal(input logic [2:0] f3,
                                 input logic [31:0] a);
        case (f3)
            3'd0, 3'd4: return 1'b1;
            3'd1, 3'd5: return (a % 2) == 0;
            3'd2:       return (a % 4) == 0;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] model_load(
        input logic [2:0] f3, input logic [31:0] a,
        input logic [31:0] rdata);
        logic [31:0] s;
        s = rdata >> (8 * (a % 4));
        case (f3)
            3'd0: return {{24{s[7]}}, s[7:0]};
            3'd4: return s & 32'h0000_00FF;
            3'd1: return {{16{s[15]}}, s[15:0]};
            3'd5: return s & 32'h0000_FFFF;
            default: return rdata;
        endcase
    endfunction

    // per-cycle compare against the expected timeline
    always @(negedge CLK) begin
        if (!RST_N) begin
            chk("rst_write", 32'(WRITE), 0);
            chk("rst_waddr", 32'(inaddr_w), 0);
            chk("rst_wdata", indata_w, 0);
            chk("rst_req", 32'(bus.mem_req), 0);
            chk("rst_maddr", bus.mem_addr, 0);
            chk("rst_fault", 32'(fault), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_ready", 32'(bus.in_ready), 1);
        end else begin
            w_e = exp_w.exists(cyc);
            r_e = exp_r.exists(cyc);
            chk("write", 32'(WRITE), 32'(w_e));
            if (w_e && WRITE) begin
                chk("waddr", 32'(inaddr_w),
                    32'(exp_w[cyc].rd));
                chk("wdata", indata_w, exp_w[cyc].d);
            end
            chk("fault", 32'(fault),
                32'(exp_f.exists(cyc)));
            chk("mem_req", 32'(bus.mem_req), 32'(r_e));
            if (r_e)
                chk("mem_addr", bus.mem_addr, exp_r[cyc]);
            chk("busy", 32'(busy), 32'(r_e));
            chk("in_ready", 32'(bus.in_ready), 32'(!r_e));
        end
    end

    task automatic idle_noise();
        bus.in_valid  = 1'b0;
        bus.mem_ack   = 1'($urandom_range(0, 1));
        bus.mem_rdata = $urandom;
        @(negedge CLK);
    endtask

    task automatic alu(input logic [4:0] rd,
                       input logic [31:0] res,
                       input logic wen);
        int c;
        c = cyc;
        bus.in_valid   = 1'b1;
        bus.in_is_load = 1'b0;
        bus.in_wen     = wen;
        bus.in_funct3  = 3'($urandom);
        bus.in_rd      = rd;
        bus.in_result  = res;
        bus.mem_ack    = 1'($urandom_range(0, 1));
        bus.mem_rdata  = $urandom;
        if (wen && rd != 0)
            exp_w[c+1] = '{rd, res};
        @(negedge CLK);
        bus.in_valid = 1'b0;
    endtask

    task automatic load(input logic [2:0] f3,
                        input logic [31:0] a,
                        input logic [31:0] rdata,
                        input int d,
                        input logic [4:0] rd,
                        input logic wen,
                        input bit dochk,
                        input logic [31:0] lit_ma,
                        input logic [31:0] lit_d);
        int c;
        int p;
        c = cyc;
        bus.in_valid   = 1'b1;
        bus.in_is_load = 1'b1;
        bus.in_wen     = wen;
        bus.in_funct3  = f3;
        bus.in_rd      = rd;
        bus.in_result  = a;
        bus.mem_ack    = 1'($urandom_range(0, 1));
        bus.mem_rdata  = $urandom;
        if (!legal(f3, a)) begin
            exp_f[c+1] = 1'b1;
            @(negedge CLK);
            bus.in_valid = 1'b0;
            if (dochk) chk("lit_fault", 32'(fault), 1);
            return;
        end
        p = c + 1 + d;
        for (int k = c + 1; k <= p; k++)
            exp_r[k] = a & ~32'd3;
        if (wen && rd != 0)
            exp_w[p+1] = '{rd, model_load(f3, a, rdata)};
        @(negedge CLK);
        if (dochk) chk("lit_maddr", bus.mem_addr, lit_ma);
        // upstream noise while busy must never be taken
        for (int k = 0; k <= d; k++) begin
            bus.in_valid   = 1'($urandom_range(0, 1));
            bus.in_is_load = 1'($urandom_range(0, 1));
            bus.in_wen     = 1'b1;
            bus.in_rd      = 5'($urandom_range(1, 31));
            bus.in_funct3  = 3'($urandom);
            bus.in_result  = $urandom;
            bus.mem_ack    = (k == d);
            bus.mem_rdata  = (k == d) ? rdata : $urandom;
            @(negedge CLK);
        end
        bus.in_valid = 1'b0;
        bus.mem_ack  = 1'b0;
        if (dochk) chk("lit_data", indata_w, lit_d);
    endtask

    task automatic reset_in_req();
        int c;
        c = cyc;
        bus.in_valid   = 1'b1;
        bus.in_is_load = 1'b1;
        bus.in_wen     = 1'b1;
        bus.in_funct3  = 3'b010;
        bus.in_rd      = 5'd9;
        bus.in_result  = 32'h0000_0200;
        bus.mem_ack    = 1'b0;
        exp_r[c+1] = 32'h0000_0200;
        @(negedge CLK);
        bus.in_valid = 1'b0;
        @(posedge CLK);
        #2 RST_N = 1'b0;
        #1;
        chk("async_req", 32'(bus.mem_req), 0);
        chk("async_busy", 32'(busy), 0);
        chk("async_ready", 32'(bus.in_ready), 1);
        exp_w.delete();
        exp_r.delete();
        exp_f.delete();
        repeat (2) @(negedge CLK);
        @(posedge CLK);
        #2 RST_N = 1'b1;
        @(negedge CLK);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h1234_5678;
        @(negedge CLK);
        bus.mem_ack = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    initial begin
        int r;
        logic [2:0] f3;
        logic [31:0] a;
        bus.in_valid   = 1'b0;
        bus.in_is_load = 1'b0;
        bus.in_wen     = 1'b0;
        bus.in_funct3  = 3'b0;
        bus.in_rd      = 5'd0;
        bus.in_result  = 32'd0;
        bus.mem_ack    = 1'b0;
        bus.mem_rdata  = 32'd0;
        repeat (3) @(negedge CLK);
        @(posedge CLK);
        #2 RST_N = 1'b1;
        @(negedge CLK);

        alu(5'd5, 32'h0000_1234, 1'b1);
        alu(5'd6, 32'h0000_DEAD, 1'b1);
        alu(5'd0, 32'h0000_0055, 1'b1);
        idle_noise();
        load(3'b000, 32'h103, 32'h80FF_0000, 0, 5'd7,
             1'b1, 1, 32'h100, 32'hFFFF_FF80);
        load(3'b100, 32'h103, 32'h80FF_0000, 0, 5'd8,
             1'b1, 1, 32'h100, 32'h0000_0080);
        load(3'b001, 32'h102, 32'h8001_5555, 2, 5'd3,
             1'b1, 1, 32'h100, 32'hFFFF_8001);
        load(3'b101, 32'h102, 32'h8001_5555, 2, 5'd4,
             1'b1, 1, 32'h100, 32'h0000_8001);
        load(3'b010, 32'h102, 32'h0, 0, 5'd2,
             1'b1, 1, 32'h0, 32'h0);
        load(3'b011, 32'h100, 32'h0, 0, 5'd2,
             1'b1, 1, 32'h0, 32'h0);
        load(3'b010, 32'h104, 32'hCAFE_F00D, 1, 5'd0,
             1'b1, 0, 32'h0, 32'h0);
        idle_noise();
        reset_in_req();

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            if (r < 4) begin
                alu(5'($urandom_range(0, 31)), $urandom,
                    1'($urandom_range(0, 3) != 0));
            end else if (r < 8) begin
                f3 = 3'($urandom);
                a = $urandom;
                if ($urandom_range(0, 1) == 1)
                    a[1:0] = 2'b00;
                load(f3, a, $urandom, $urandom_range(0, 3),
                     5'($urandom_range(0, 31)),
                     1'($urandom_range(0, 3) != 0),
                     0, 32'h0, 32'h0);
            end else begin
                idle_noise();
            end
        end
        repeat (3) idle_noise();
        bus.mem_ack = 1'b0;
        @(negedge CLK);
        $display("[TB] %0d tests run, %0d failed",
                 tests, fails);
        $finish;
    end

endmodule
